vector_frame_writer: RTL
========================

Name: vector_frame_writer

Overview:
- Producer side of the vector display list: assembles an incoming byte stream into DATAWIDTH-bit vector command words and writes them into a double-buffered vector RAM.
- The display engine reads that RAM and raises halt_flag at the end of each frame.
- On the first completed frame edge after a full list has been written, the block swaps banks and pulses go_flag so the engine starts on the new list.
- Sits between the host byte link (UART RX or a bench driver) and the vector RAM, all in the clk100MHz domain.

Parameters:
- ADDRESSWIDTH, 10, word address width per bank; the RAM holds 2 banks.
- DATAWIDTH, 24, command word width; opcode is bits [DATAWIDTH-1:DATAWIDTH-2], payload is the rest.
- BYTES_PER_WORD, 3, bytes per word, MSB first; must equal ceil(DATAWIDTH/8).
- TIMEOUT_CYCLES, 100000, idle cycles after which a partial word is discarded.

Ports:
- clk100MHz  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_byte  in  8  host byte.
- in_valid  in  1  in_byte valid.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- halt_flag  in  1  end-of-frame level from the display engine.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  ADDRESSWIDTH+1  {bank, word address}.
- wr_data  out  DATAWIDTH  command word.
- rd_bank  out  1  bank the display engine reads.
- go_flag  out  1  one-cycle pulse: new frame is live.
- overflow  out  1  sticky: list truncated.

Behaviour:
- Reset values:
  - rd_bank=0, write bank = ~rd_bank = 1, word address 0, byte count 0.
  - state FILL, so in_ready=1.
  - wr_en=0, wr_addr=0, wr_data=0, go_flag=0, overflow=0, idle counter 0.
- States: FILL, WAIT_SWAP. in_ready = (state==FILL), combinational.
- Byte assembly:
  - Each accepted byte shifts into the word register, MSB first.
  - The byte counter runs 0..BYTES_PER_WORD-1.
  - Bits above DATAWIDTH in the shifted bytes are dropped.
- Word write, when the final byte is accepted in cycle N:
  - In N+1: wr_en=1, wr_addr={~rd_bank, addr}, wr_data=word; the address increments and the byte counter clears.
  - Back-to-back bytes are accepted in N+1, so throughput is 1 byte/cycle.
- HALT opcode (2'b11) word:
  - Written as above.
  - state<=WAIT_SWAP in the same cycle as the write, so in_ready=0 from N+1.
- Overflow:
  - Applies when the final byte of a non-HALT word lands at addr = 2^ADDRESSWIDTH-1.
  - The block writes a HALT word ({2'b11, zeros}) instead of the received word.
  - overflow<=1 (sticky until reset), state<=WAIT_SWAP.
- halt_flag handling:
  - A rising edge is detected with one register: rise = halt_flag && !halt_q.
  - rise in WAIT_SWAP: next cycle rd_bank toggles, go_flag=1 for exactly one cycle, addr<=0, state<=FILL.
  - rise in FILL: ignored; the engine redisplays the current bank.
  - rise in the same cycle the HALT word's final byte is accepted: ignored; the swap waits for the next rise.
  - halt_flag held high produces only one swap.
- Idle timeout:
  - Active only in FILL with byte count ≠ 0.
  - The idle counter counts cycles with no accepted byte.
  - At TIMEOUT_CYCLES the partial word is discarded: byte count 0, no write, address unchanged.
  - Any accepted byte clears the counter.
- Reset mid-operation (rst_n low at any time):
  - All state returns to reset values immediately.
  - A partial word is lost; the write bank reverts to 1.

Decomposition:
- vector_pkg holds:
  - the opcode typedef (LINE=2'b00, MOVE=2'b01, RSVD=2'b10, HALT=2'b11);
  - the DATAWIDTH and ADDRESSWIDTH constants;
  - the state enum.
- One sub-module, byte_word_assembler: shift register, byte counter, idle timeout, and a word_valid pulse.
- The top of this block holds the FSM, addressing, bank swap and overflow.

Test Plan:
1. Reset, then bytes 00 12 34, 40 56 78, C0 00 00 → three writes: addr {1,0}=0x001234, {1,1}=0x405678, {1,2}=0xC00000. in_ready=0 after the third; rd_bank=0, go_flag=0.
2. From 1, pulse halt_flag → exactly one go_flag pulse, one cycle after the rise; rd_bank=1. The next list writes to bank 0 starting at addr 0.
3. halt_flag rising while in FILL with a partial list, then HALT completes, then a second rise → no swap on the first rise; swap on the second.
4. ADDRESSWIDTH=2: send 4 LINE words, no HALT → addr 3 holds 0xC00000, overflow=1, in_ready=0. After a halt_flag rise, overflow stays 1.
5. Send 2 bytes, idle TIMEOUT_CYCLES (set to 50), then 00 AA BB → single write 0x00AABB at addr 0; no write of the partial word.
6. Drop rst_n for 1 cycle mid-word and again in WAIT_SWAP → all outputs return to reset values, and the next complete word writes to {1,0}.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared types and default sizes for the vector display-list writer.
package vector_pkg;

  localparam int unsigned DATAWIDTH    = 24;
  localparam int unsigned ADDRESSWIDTH = 10;

  // Command opcode, carried in the top two bits of each word.
  typedef enum logic [1:0] {
    OpLine = 2'b00,
    OpMove = 2'b01,
    OpRsvd = 2'b10,
    OpHalt = 2'b11
  } opcode_e;

  typedef enum logic [0:0] {
    StFill     = 1'b0,
    StWaitSwap = 1'b1
  } state_e;

endpackage

// File: rtl/byte_word_assembler.sv
// Packs accepted bytes MSB first into command words and drops stale partial words.
module byte_word_assembler #(
  parameter int unsigned DATAWIDTH      = 24,
  parameter int unsigned BYTES_PER_WORD = 3,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [7:0]           byte_i,
  input  logic                 accept_i,
  input  logic                 active_i,
  output logic                 word_valid_o,
  output logic [DATAWIDTH-1:0] word_o
);

  localparam int unsigned CntW  = $clog2(BYTES_PER_WORD + 1);
  localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);

  // Only the low DATAWIDTH-8 bits can survive into the next word, so keep just those.
  logic [DATAWIDTH-9:0] word_q, word_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdleW-1:0]     idle_q, idle_d;

  // The word is complete in the cycle its last byte is accepted.
  assign word_o = {word_q, byte_i};

  // Shift, count bytes, and age out a partial word after a long idle gap.
  always_comb begin
    word_d       = word_q;
    cnt_d        = cnt_q;
    idle_d       = idle_q;
    word_valid_o = 1'b0;
    if (accept_i) begin
      word_d = word_o[DATAWIDTH-9:0];
      idle_d = '0;
      if (cnt_q == CntW'(BYTES_PER_WORD - 1)) begin
        cnt_d        = '0;
        word_valid_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (active_i && (cnt_q != '0)) begin
      if (idle_q == IdleW'(TIMEOUT_CYCLES - 1)) begin
        cnt_d  = '0;
        idle_d = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end else begin
      idle_d = '0;
    end
  end

  // Assembler state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      cnt_q  <= '0;
      idle_q <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
      idle_q <= idle_d;
    end
  end

endmodule

// File: rtl/vector_frame_writer.sv
// Writes assembled command words into the back bank and swaps banks at frame end.
module vector_frame_writer #(
  parameter int unsigned ADDRESSWIDTH   = vector_pkg::ADDRESSWIDTH,
  parameter int unsigned DATAWIDTH      = vector_pkg::DATAWIDTH,
  parameter int unsigned BYTES_PER_WORD = 3,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk100MHz,
  input  logic                  rst_n,
  input  logic [7:0]            in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  halt_flag,
  output logic                  wr_en,
  output logic [ADDRESSWIDTH:0] wr_addr,
  output logic [DATAWIDTH-1:0]  wr_data,
  output logic                  rd_bank,
  output logic                  go_flag,
  output logic                  overflow
);

  import vector_pkg::*;

  localparam logic [DATAWIDTH-1:0] HaltWord = {OpHalt, {(DATAWIDTH - 2){1'b0}}};

  state_e                  state_q, state_d;
  logic                    rd_bank_q, rd_bank_d;
  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDRESSWIDTH:0]   wr_addr_q, wr_addr_d;
  logic [DATAWIDTH-1:0]    wr_data_q, wr_data_d;
  logic                    go_q, go_d;
  logic                    ovf_q, ovf_d;
  logic                    halt_q;

  logic                    accept;
  logic                    rise;
  logic                    word_valid;
  logic [DATAWIDTH-1:0]    word;
  opcode_e                 op;

  assign in_ready = (state_q == StFill);
  assign accept   = in_valid && in_ready;
  assign rise     = halt_flag && !halt_q;
  assign op       = opcode_e'(word[DATAWIDTH-1 -: 2]);

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_bank  = rd_bank_q;
  assign go_flag  = go_q;
  assign overflow = ovf_q;

  byte_word_assembler #(
    .DATAWIDTH     (DATAWIDTH),
    .BYTES_PER_WORD(BYTES_PER_WORD),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_asm (
    .clk_i       (clk100MHz),
    .rst_ni      (rst_n),
    .byte_i      (in_byte),
    .accept_i    (accept),
    .active_i    (in_ready),
    .word_valid_o(word_valid),
    .word_o      (word)
  );

  // Next-state: write words into the bank not being displayed, swap on frame end.
  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    go_d      = 1'b0;
    ovf_d     = ovf_q;
    unique case (state_q)
      StFill: begin
        // A frame edge here just redisplays the current bank.
        if (word_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {~rd_bank_q, addr_q};
          if (op == OpHalt) begin
            wr_data_d = word;
            state_d   = StWaitSwap;
          end else if (addr_q == {ADDRESSWIDTH{1'b1}}) begin
            // Bank full: terminate the list so the engine never runs off the end.
            wr_data_d = HaltWord;
            ovf_d     = 1'b1;
            state_d   = StWaitSwap;
          end else begin
            wr_data_d = word;
            addr_d    = addr_q + 1'b1;
          end
        end
      end
      StWaitSwap: begin
        if (rise) begin
          rd_bank_d = ~rd_bank_q;
          go_d      = 1'b1;
          addr_d    = '0;
          state_d   = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  // State, addressing and output registers.
  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFill;
      rd_bank_q <= 1'b0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      go_q      <= 1'b0;
      ovf_q     <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      go_q      <= go_d;
      ovf_q     <= ovf_d;
      halt_q    <= halt_flag;
    end
  end

endmodule
